// File: rtl/binary_multiple_of_7_serializer_pkg.sv
// Shared constants, state encoding and check-field helper for the mod-7 framed serializer.
package binary_multiple_of_7_serializer_pkg;

  localparam int MOD7_MODULUS = 7;
  localparam int CHECK_WIDTH  = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Appending C = (7 - r) mod 7 as three low bits makes 8*payload + C divisible by 7.
  function automatic logic [CHECK_WIDTH-1:0] check_field(input logic [CHECK_WIDTH-1:0] r);
    return (r == '0) ? '0 : CHECK_WIDTH'(MOD7_MODULUS) - r;
  endfunction

endpackage

// File: rtl/binary_multiple_of_7_serializer_if.sv
// Request/serial-output bundle between a frame producer and the mod-7 serializer.
interface binary_multiple_of_7_serializer_if
  import binary_multiple_of_7_serializer_pkg::*;
  #(parameter int PAYLOAD_WIDTH = 8);

  logic [PAYLOAD_WIDTH-1:0] Data;
  logic                     Start;
  logic                     STRING;
  logic                     Frame;
  logic                     Busy;
  logic                     Done;
  logic [CHECK_WIDTH-1:0]   Remainder;

  modport master (output Data, Start, input STRING, Frame, Busy, Done, Remainder);
  modport slave  (input Data, Start, output STRING, Frame, Busy, Done, Remainder);

endinterface

// File: rtl/binary_multiple_of_7_serializer_mod7_step.sv
// One MSB-first step of a serial residue-mod-7 update; shared with the matching checker.
module mod7_step
  import binary_multiple_of_7_serializer_pkg::*;
(
  input  logic [CHECK_WIDTH-1:0] r_i,
  input  logic                   bit_i,
  output logic [CHECK_WIDTH-1:0] r_next_o
);

  logic [CHECK_WIDTH:0] sum;

  // 2*r + bit never exceeds 13, so a single conditional subtract reduces it.
  assign sum      = {r_i, bit_i};
  assign r_next_o = (sum >= (CHECK_WIDTH+1)'(MOD7_MODULUS))
                    ? CHECK_WIDTH'(sum - (CHECK_WIDTH+1)'(MOD7_MODULUS))
                    : sum[CHECK_WIDTH-1:0];

endmodule

// File: rtl/binary_multiple_of_7_serializer.sv
// Serializes payload MSB first followed by a 3-bit field that makes the frame a multiple of 7.
//
// state   | meaning
// IDLE    | waiting for Start; outputs quiet
// PAYLOAD | driving payload bits, updating residue
// CHECK   | driving C[2], C[1], C[0]
// DONE    | one-cycle Done pulse, Start ignored
module binary_multiple_of_7_serializer
  import binary_multiple_of_7_serializer_pkg::*;
  #(parameter int PAYLOAD_WIDTH = 8)
(
  input  logic                               Clock,
  input  logic                               Reset,
  binary_multiple_of_7_serializer_if.slave   bus
);

  localparam int                CNT_W    = $clog2(PAYLOAD_WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(PAYLOAD_WIDTH - 1);

  state_t                   state_q, state_d;
  logic [PAYLOAD_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [1:0]               chk_q, chk_d;
  logic [CHECK_WIDTH-1:0]   resid_q, resid_d;
  logic [CHECK_WIDTH-1:0]   resid_step;
  logic [CHECK_WIDTH-1:0]   check_bits;
  logic                     string_s, frame_s, done_s;

  mod7_step u_step (
    .r_i      (resid_q),
    .bit_i    (shift_q[PAYLOAD_WIDTH-1]),
    .r_next_o (resid_step)
  );

  assign check_bits = check_field(resid_q);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      chk_q   <= '0;
      resid_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      chk_q   <= chk_d;
      resid_q <= resid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    chk_d    = chk_q;
    resid_d  = resid_q;
    string_s = 1'b0;
    frame_s  = 1'b0;
    done_s   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          state_d = ST_PAYLOAD;
          shift_d = bus.Data;
          cnt_d   = '0;
          resid_d = '0;
        end
      end
      ST_PAYLOAD: begin
        frame_s  = 1'b1;
        string_s = shift_q[PAYLOAD_WIDTH-1];
        resid_d  = resid_step;
        shift_d  = shift_q << 1;
        if (cnt_q == LAST_BIT) begin
          state_d = ST_CHECK;
          chk_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CHECK: begin
        frame_s = 1'b1;
        case (chk_q)
          2'd0:    string_s = check_bits[2];
          2'd1:    string_s = check_bits[1];
          default: string_s = check_bits[0];
        endcase
        chk_d = chk_q + 1'b1;
        if (chk_q == 2'd2) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_s  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.STRING    = string_s;
  assign bus.Frame     = frame_s;
  assign bus.Done      = done_s;
  assign bus.Busy      = (state_q != ST_IDLE);
  assign bus.Remainder = resid_q;

endmodule

// File: tb/tb_binary_multiple_of_7_serializer.sv
// Bench for the mod-7 serializer: positional frame model, per-cycle compare, loopback residue check.
module tb_binary_multiple_of_7_serializer;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  binary_multiple_of_7_serializer_if #(.PAYLOAD_WIDTH(W)) bus_if ();

  binary_multiple_of_7_serializer #(.PAYLOAD_WIDTH(W)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Model: m_pos 0 = idle, 1..W+3 = frame bit index (1-based), W+4 = done cycle.
  int m_pos = 0;
  int m_d = 0;
  int m_hold = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pos  = 0;
      m_hold = 0;
    end else if (m_pos == 0) begin
      if (bus_if.Start) begin
        m_pos = 1;
        m_d   = int'(bus_if.Data);
      end
    end else if (m_pos == W + 4) begin
      m_pos  = 0;
      m_hold = m_d % 7;
    end else begin
      m_pos++;
    end
  end

  int coll = 0, nb = 0, lb_r = 0;
  int last_frame = -1, last_nb = 0, last_rem = -1;
  int frames_done = 0;
  int gap_cnt = 1000, last_gap = -1;
  bit prev_frame = 1'b0;

  always @(negedge clk) begin
    int fv, e_str, e_frame, e_busy, e_done, e_rem;
    fv      = m_d * 8 + (7 - m_d % 7) % 7;
    e_frame = (m_pos >= 1 && m_pos <= W + 3) ? 1 : 0;
    e_str   = e_frame ? ((fv >> (W + 3 - m_pos)) & 1) : 0;
    e_busy  = (m_pos != 0) ? 1 : 0;
    e_done  = (m_pos == W + 4) ? 1 : 0;
    if (m_pos == 0)      e_rem = m_hold;
    else if (m_pos <= W) e_rem = (m_d >> (W - m_pos + 1)) % 7;
    else                 e_rem = m_d % 7;
    chk("STRING", int'(bus_if.STRING), e_str);
    chk("Frame", int'(bus_if.Frame), e_frame);
    chk("Busy", int'(bus_if.Busy), e_busy);
    chk("Done", int'(bus_if.Done), e_done);
    chk("Remainder", int'(bus_if.Remainder), e_rem);

    if (!rst) begin
      coll = 0; nb = 0; lb_r = 0;
    end else begin
      if (bus_if.Frame) begin
        if (!prev_frame) last_gap = gap_cnt;
        gap_cnt = 0;
        coll = (coll << 1) | int'(bus_if.STRING);
        nb++;
        lb_r = (2 * lb_r + int'(bus_if.STRING)) % 7;
      end else begin
        gap_cnt++;
      end
      if (bus_if.Done) begin
        last_frame = coll;
        last_nb    = nb;
        last_rem   = int'(bus_if.Remainder);
        chk("loopback_divisible", (lb_r == 0) ? 1 : 0, 1);
        frames_done++;
        coll = 0; nb = 0; lb_r = 0;
      end
    end
    prev_frame = bus_if.Frame;
  end

  task automatic send(input int d);
    int base;
    base = frames_done;
    @(posedge clk); #1;
    bus_if.Start = 1'b1;
    bus_if.Data  = 8'(d);
    @(posedge clk); #1;
    bus_if.Start = 1'b0;
    repeat (W + 6) @(posedge clk);
    #1;
    chk("frame_completed", frames_done, base + 1);
  endtask

  initial begin
    int base;
    bus_if.Start = 1'b0;
    bus_if.Data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_STRING", int'(bus_if.STRING), 0);
    chk("reset_Busy", int'(bus_if.Busy), 0);
    chk("reset_Remainder", int'(bus_if.Remainder), 0);
    rst = 1'b1;

    send(8'h05);
    chk("h05_frame", last_frame, 42);
    chk("h05_bits", last_nb, 11);
    chk("h05_rem", last_rem, 5);

    send(8'hFF);
    chk("hFF_frame", last_frame, 2044);
    chk("hFF_rem", last_rem, 3);

    send(8'h00);
    chk("h00_frame", last_frame, 0);
    chk("h00_rem", last_rem, 0);

    send(8'h07);
    chk("h07_frame", last_frame, 56);
    chk("h07_check", last_frame & 7, 0);
    chk("h07_rem", last_rem, 0);

    // Start held high: back-to-back frames, mid-frame Data changes ignored
    base = frames_done;
    @(posedge clk); #1;
    bus_if.Start = 1'b1;
    bus_if.Data  = 8'h05;
    @(posedge clk); #1;
    bus_if.Data = 8'hFF;
    repeat (5) @(posedge clk);
    #1;
    bus_if.Data = 8'h05;
    for (int i = 0; i < 40 && frames_done < base + 1; i++) @(posedge clk);
    chk("b2b_first_done", frames_done, base + 1);
    chk("b2b_first_frame", last_frame, 42);
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_gap", last_gap, 2);
    chk("b2b_second_busy", int'(bus_if.Busy), 1);
    bus_if.Start = 1'b0;
    bus_if.Data  = 8'h3C;
    for (int i = 0; i < 40 && frames_done < base + 2; i++) @(posedge clk);
    #1;
    chk("b2b_second_done", frames_done, base + 2);
    chk("b2b_second_frame", last_frame, 42);
    repeat (3) @(posedge clk);

    // Reset during payload bit 4
    base = frames_done;
    @(posedge clk); #1;
    bus_if.Start = 1'b1;
    bus_if.Data  = 8'hA5;
    @(posedge clk); #1;
    bus_if.Start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_abort_rem", int'(bus_if.Remainder), 3);
    rst = 1'b0;
    #1;
    chk("abort_STRING", int'(bus_if.STRING), 0);
    chk("abort_Frame", int'(bus_if.Frame), 0);
    chk("abort_Busy", int'(bus_if.Busy), 0);
    chk("abort_Done", int'(bus_if.Done), 0);
    chk("abort_Remainder", int'(bus_if.Remainder), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_resume_busy", int'(bus_if.Busy), 0);
    chk("abort_no_frame", frames_done, base);
    send(8'hFF);
    chk("post_reset_frame", last_frame, 2044);
    chk("post_reset_rem", last_rem, 3);

    base = frames_done;
    for (int d = 0; d < 256; d++) send(d);
    chk("sweep_frames", frames_done, base + 256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/binary_multiple_of_7_serializer.md
BINARY_MULTIPLE_OF_7_SERIALIZER -- requirements
Module: binary_multiple_of_7_serializer

Interface
REQ-001 Parameter PAYLOAD_WIDTH, default 8, SHALL set the number of payload bits per frame.
REQ-002 Port Clock, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port Reset, input, 1, SHALL be the asynchronous, active-low reset.
REQ-004 Port Data, input, PAYLOAD_WIDTH, SHALL carry the payload word; it is sampled only on accepted Start.
REQ-005 Port Start, input, 1, SHALL request transmission of Data.
REQ-006 Port STRING, output, 1, SHALL carry the serial frame bit, MSB first.
REQ-007 Port Frame, output, 1, SHALL be high exactly while STRING carries a valid frame bit.
REQ-008 Port Busy, output, 1, SHALL be high whenever the state is not IDLE.
REQ-009 Port Done, output, 1, SHALL pulse high for one cycle after the last frame bit.
REQ-010 Port Remainder, output, 3, SHALL show the running residue mod 7 of the payload bits sent so far.

Function
REQ-011 The frame SHALL be the payload followed by a 3-bit check field C, PAYLOAD_WIDTH+3 bits in total, MSB first.
REQ-012 The integer value of the frame SHALL be divisible by 7, so that a downstream divisibility-by-7 checker reads residue 0 after the last bit.
REQ-013 The residue SHALL be computed serially, r_next = (2*r + bit) mod 7, starting at r = 0, for each payload bit as it is driven.
REQ-014 The check field SHALL be C = (7 - r) mod 7, where r is the residue after the last payload bit; C is always in the range 0..6.
REQ-015 The FSM SHALL have states IDLE, PAYLOAD, CHECK and DONE.
REQ-016 In IDLE with Start=1, the block SHALL load Data into a shift register, clear the residue and the bit counter, and enter PAYLOAD on the next edge.
REQ-017 The first frame bit (Data MSB) SHALL appear on STRING with Frame=1 in the cycle after Start is sampled (latency 1).
REQ-018 PAYLOAD SHALL last exactly PAYLOAD_WIDTH cycles, driving one bit per cycle, then enter CHECK.
REQ-019 CHECK SHALL last exactly 3 cycles, driving C[2], C[1], C[0] in that order, then enter DONE.
REQ-020 DONE SHALL last one cycle with Done=1 and Frame=0, then return to IDLE.
REQ-021 Start SHALL be ignored when the state is not IDLE; changes on Data during a frame SHALL NOT alter the frame.
REQ-022 If Start=1 during the DONE cycle, it SHALL be ignored.
REQ-023 If Start=1 in the IDLE cycle that follows DONE, a new frame SHALL begin with a minimum gap of 2 cycles between frames.
REQ-024 When Frame=0, STRING SHALL be 0.
REQ-025 Remainder SHALL hold its final payload residue through CHECK and DONE, and SHALL clear to 0 on the next accepted Start.
REQ-026 The bit counter SHALL be sized ceil(log2(PAYLOAD_WIDTH+1)) bits and SHALL NOT wrap within a frame.

Reset
REQ-027 Reset=0 SHALL immediately force the state to IDLE and STRING, Frame, Busy, Done and Remainder to 0, including when a frame is in progress.
REQ-028 A frame aborted by reset SHALL NOT resume; the first Start sampled after reset release SHALL begin a fresh frame.

Structure
REQ-029 A shared package SHALL hold MOD7_MODULUS=7, CHECK_WIDTH=3 and the state encoding (2 bits: IDLE=0, PAYLOAD=1, CHECK=2, DONE=3).
REQ-030 The residue update SHALL be a combinational sub-module mod7_step (inputs: r[2:0], bit; output: r_next[2:0]), reusable by the matching checker.

Verification
REQ-031 Data=8'h05, Start pulse -> STRING=00000101_010 over 11 Frame cycles, value 42, Remainder=5, Done one cycle later.
REQ-032 Data=8'hFF -> STRING=11111111_100, value 2044 = 7*292, Remainder=3.
REQ-033 Data=8'h00 and Data=8'h07 -> check field 000 in both cases, Remainder=0.
REQ-034 Start held high continuously with Data=8'h05 -> back-to-back frames with exactly 2 non-Frame cycles (DONE, IDLE) between them, and Data changes mid-frame ignored.
REQ-035 Reset=0 asserted at payload bit 4 -> all outputs 0 in the same cycle; after release, Start with Data=8'hFF -> full correct frame.
REQ-036 Loopback into the existing divisibility-by-7 checker for all 256 Data values -> Divisible=1 after every frame's final bit.
